// File: rtl/uart_core_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_cfg
// Purpose  : Configurable UART transmit/receive engine. 5-8 data bits,
//            optional even/odd parity, 1 or 2 TX stop bits, break detection
//            and per-frame error flags, paced by an external oversample tick.
// Options  : UART_CORE_CFG_MAJORITY_EN - each RX bit decision is a 2-of-3
//            majority vote around mid-bit instead of a single sample.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_cfg #(
  parameter int OVERSAMPLE = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n_sync,
  input  logic       en,
  input  logic       clk_en,
  input  logic [1:0] cfg_nbits,
  input  logic       cfg_par_en,
  input  logic       cfg_par_odd,
  input  logic       cfg_stop2,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_hold,
  output logic       tx_busy,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_overrun,
  output logic       rx_break
);

  localparam int                 c_cnt_w     = $clog2(OVERSAMPLE);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [2:0]         c_filt_last = 3'(FILTER_LEN - 1);

`ifdef UART_CORE_CFG_MAJORITY_EN
  // Start decision lands on the third vote sample, one tick past mid-bit.
  localparam logic [c_cnt_w-1:0] c_start_dec = c_cnt_w'(OVERSAMPLE / 2);
`else
  localparam logic [c_cnt_w-1:0] c_start_dec = c_cnt_w'(OVERSAMPLE / 2 - 1);
`endif

  // Mask of the configured data bits (5 + nbits).
  function automatic logic [7:0] width_mask(input logic [1:0] nbits);
    width_mask = 8'hFF >> (2'd3 - nbits);
  endfunction

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP1  = 3'd4,
    TX_STOP2  = 3'd5
  } tx_state_t;

  tx_state_t          r_tx_state,  w_tx_state_nxt;
  logic [c_cnt_w-1:0] r_tx_cnt,    w_tx_cnt_nxt;
  logic [7:0]         r_tx_shift,  w_tx_shift_nxt;
  logic [2:0]         r_tx_bitcnt, w_tx_bitcnt_nxt;
  logic [2:0]         r_tx_last,   w_tx_last_nxt;
  logic               r_tx_par_en, w_tx_par_en_nxt;
  logic               r_tx_stop2,  w_tx_stop2_nxt;
  logic               r_tx_par,    w_tx_par_nxt;
  logic               r_tx,        w_tx_nxt;
  logic [7:0]         w_tx_masked;
  logic               w_tx_fire;
  logic               w_tx_bit_end;

  assign tx_ready     = rst_n_sync && en && (r_tx_state == TX_IDLE) && !tx_hold;
  assign tx_busy      = (r_tx_state != TX_IDLE);
  assign tx           = r_tx;
  assign w_tx_fire    = tx_valid && tx_ready;
  assign w_tx_masked  = tx_data & width_mask(cfg_nbits);
  assign w_tx_bit_end = clk_en && (r_tx_cnt == c_tick_last);

  // TX next-state: frame sequencing, shift register and registered line value.
  always_comb begin
    w_tx_state_nxt  = r_tx_state;
    w_tx_cnt_nxt    = r_tx_cnt;
    w_tx_shift_nxt  = r_tx_shift;
    w_tx_bitcnt_nxt = r_tx_bitcnt;
    w_tx_last_nxt   = r_tx_last;
    w_tx_par_en_nxt = r_tx_par_en;
    w_tx_stop2_nxt  = r_tx_stop2;
    w_tx_par_nxt    = r_tx_par;
    w_tx_nxt        = r_tx;
    if (!en) begin
      w_tx_state_nxt = TX_IDLE;
      w_tx_cnt_nxt   = '0;
      w_tx_nxt       = 1'b1;
    end else begin
      if ((r_tx_state != TX_IDLE) && clk_en) begin
        w_tx_cnt_nxt = r_tx_cnt + c_one;
      end
      case (r_tx_state)
        TX_IDLE: begin
          w_tx_nxt = 1'b1;
          if (w_tx_fire) begin
            w_tx_shift_nxt  = w_tx_masked;
            w_tx_bitcnt_nxt = 3'd0;
            w_tx_last_nxt   = 3'd4 + {1'b0, cfg_nbits};
            w_tx_par_en_nxt = cfg_par_en;
            w_tx_stop2_nxt  = cfg_stop2;
            w_tx_par_nxt    = (^w_tx_masked) ^ cfg_par_odd;
            w_tx_cnt_nxt    = '0;
            w_tx_state_nxt  = TX_START;
            w_tx_nxt        = 1'b0;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            w_tx_state_nxt = TX_DATA;
            w_tx_nxt       = r_tx_shift[0];
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            if (r_tx_bitcnt == r_tx_last) begin
              if (r_tx_par_en) begin
                w_tx_state_nxt = TX_PARITY;
                w_tx_nxt       = r_tx_par;
              end else begin
                w_tx_state_nxt = TX_STOP1;
                w_tx_nxt       = 1'b1;
              end
            end else begin
              w_tx_bitcnt_nxt = r_tx_bitcnt + 3'd1;
              w_tx_nxt        = r_tx_shift[1];
            end
          end
        end
        TX_PARITY: begin
          if (w_tx_bit_end) begin
            w_tx_state_nxt = TX_STOP1;
            w_tx_nxt       = 1'b1;
          end
        end
        TX_STOP1: begin
          if (w_tx_bit_end) begin
            w_tx_state_nxt = r_tx_stop2 ? TX_STOP2 : TX_IDLE;
            w_tx_nxt       = 1'b1;
          end
        end
        TX_STOP2: begin
          if (w_tx_bit_end) begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_nxt       = 1'b1;
          end
        end
        default: begin
          w_tx_state_nxt = TX_IDLE;
          w_tx_nxt       = 1'b1;
        end
      endcase
    end
  end

  // TX state and datapath registers.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_shift  <= '0;
      r_tx_bitcnt <= '0;
      r_tx_last   <= '0;
      r_tx_par_en <= 1'b0;
      r_tx_stop2  <= 1'b0;
      r_tx_par    <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_tx_state  <= w_tx_state_nxt;
      r_tx_cnt    <= w_tx_cnt_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_tx_bitcnt <= w_tx_bitcnt_nxt;
      r_tx_last   <= w_tx_last_nxt;
      r_tx_par_en <= w_tx_par_en_nxt;
      r_tx_stop2  <= w_tx_stop2_nxt;
      r_tx_par    <= w_tx_par_nxt;
      r_tx        <= w_tx_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Receiver front end
  // --------------------------------------------------------------------------
  logic       r_rx_meta;
  logic       r_rx_sync;
  logic       r_rx_filt;
  logic       r_rx_filt_d;
  logic [2:0] r_rx_fcnt;
  logic       w_rx_fall;

  assign w_rx_fall = r_rx_filt_d && !r_rx_filt;

  // Synchronise rx and only follow it after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_filt   <= 1'b1;
      r_rx_filt_d <= 1'b1;
      r_rx_fcnt   <= '0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_sync   <= r_rx_meta;
      r_rx_filt_d <= r_rx_filt;
      if (r_rx_sync == r_rx_filt) begin
        r_rx_fcnt <= '0;
      end else if (r_rx_fcnt == c_filt_last) begin
        r_rx_filt <= r_rx_sync;
        r_rx_fcnt <= '0;
      end else begin
        r_rx_fcnt <= r_rx_fcnt + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Receiver state machine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  rx_state_t          r_rx_state,   w_rx_state_nxt;
  logic [c_cnt_w-1:0] r_rx_cnt,     w_rx_cnt_nxt;
  logic [7:0]         r_rx_shift,   w_rx_shift_nxt;
  logic [2:0]         r_rx_bitcnt,  w_rx_bitcnt_nxt;
  logic [2:0]         r_rx_last,    w_rx_last_nxt;
  logic               r_rx_par_en,  w_rx_par_en_nxt;
  logic               r_rx_par_odd, w_rx_par_odd_nxt;
  logic               r_rx_acc,     w_rx_acc_nxt;
  logic               r_rx_par_bit, w_rx_par_bit_nxt;
  logic               r_rx_any,     w_rx_any_nxt;
  logic [7:0]         r_rx_data,    w_rx_data_nxt;
  logic               r_rx_valid,   w_rx_valid_nxt;
  logic               r_rx_perr,    w_rx_perr_nxt;
  logic               r_rx_ferr,    w_rx_ferr_nxt;
  logic               r_rx_overrun, w_rx_overrun_nxt;
  logic               r_rx_break,   w_rx_break_nxt;
  logic [c_cnt_w-1:0] w_rx_dec_pt;
  logic               w_rx_dec;
  logic               w_rx_bit;

  assign w_rx_dec_pt = (r_rx_state == RX_START) ? c_start_dec : c_tick_last;
  assign w_rx_dec    = clk_en && (r_rx_cnt == w_rx_dec_pt);

`ifdef UART_CORE_CFG_MAJORITY_EN
  logic [1:0] r_rx_vote;
  logic       w_rx_s0;
  logic       w_rx_s1;

  assign w_rx_s0  = clk_en && (r_rx_cnt == (w_rx_dec_pt - c_cnt_w'(2)));
  assign w_rx_s1  = clk_en && (r_rx_cnt == (w_rx_dec_pt - c_one));
  assign w_rx_bit = (r_rx_vote[0] & r_rx_vote[1]) |
                    (r_rx_vote[0] & r_rx_filt)    |
                    (r_rx_vote[1] & r_rx_filt);

  // Capture the two earlier vote samples; the third is the live filtered line.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_rx_vote <= 2'b11;
    end else begin
      if (w_rx_s0) r_rx_vote[0] <= r_rx_filt;
      if (w_rx_s1) r_rx_vote[1] <= r_rx_filt;
    end
  end
`else
  assign w_rx_bit = r_rx_filt;
`endif

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_perr    = r_rx_perr;
  assign rx_ferr    = r_rx_ferr;
  assign rx_overrun = r_rx_overrun;
  assign rx_break   = r_rx_break;

  // RX next-state: bit decisions, frame classification and output holding.
  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_rx_cnt_nxt     = r_rx_cnt;
    w_rx_shift_nxt   = r_rx_shift;
    w_rx_bitcnt_nxt  = r_rx_bitcnt;
    w_rx_last_nxt    = r_rx_last;
    w_rx_par_en_nxt  = r_rx_par_en;
    w_rx_par_odd_nxt = r_rx_par_odd;
    w_rx_acc_nxt     = r_rx_acc;
    w_rx_par_bit_nxt = r_rx_par_bit;
    w_rx_any_nxt     = r_rx_any;
    w_rx_data_nxt    = r_rx_data;
    w_rx_valid_nxt   = r_rx_valid;
    w_rx_perr_nxt    = r_rx_perr;
    w_rx_ferr_nxt    = r_rx_ferr;
    w_rx_overrun_nxt = 1'b0;
    w_rx_break_nxt   = 1'b0;
    if (r_rx_valid && rx_ready) begin
      w_rx_valid_nxt = 1'b0;
    end
    if (!en) begin
      w_rx_state_nxt = RX_IDLE;
      w_rx_cnt_nxt   = '0;
      w_rx_data_nxt  = '0;
      w_rx_valid_nxt = 1'b0;
      w_rx_perr_nxt  = 1'b0;
      w_rx_ferr_nxt  = 1'b0;
    end else begin
      if ((r_rx_state != RX_IDLE) && (r_rx_state != RX_BREAK) && clk_en) begin
        w_rx_cnt_nxt = r_rx_cnt + c_one;
      end
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            w_rx_cnt_nxt     = '0;
            w_rx_state_nxt   = RX_START;
            w_rx_last_nxt    = 3'd4 + {1'b0, cfg_nbits};
            w_rx_par_en_nxt  = cfg_par_en;
            w_rx_par_odd_nxt = cfg_par_odd;
            w_rx_shift_nxt   = '0;
            w_rx_bitcnt_nxt  = 3'd0;
            w_rx_acc_nxt     = 1'b0;
            w_rx_any_nxt     = 1'b0;
            w_rx_par_bit_nxt = 1'b0;
          end
        end
        RX_START: begin
          if (w_rx_dec) begin
            if (w_rx_bit) begin
              w_rx_state_nxt = RX_IDLE;
            end else begin
              w_rx_cnt_nxt   = '0;
              w_rx_state_nxt = RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_dec) begin
            w_rx_shift_nxt[r_rx_bitcnt] = w_rx_bit;
            w_rx_acc_nxt = r_rx_acc ^ w_rx_bit;
            w_rx_any_nxt = r_rx_any | w_rx_bit;
            if (r_rx_bitcnt == r_rx_last) begin
              w_rx_state_nxt = r_rx_par_en ? RX_PARITY : RX_STOP;
            end else begin
              w_rx_bitcnt_nxt = r_rx_bitcnt + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          if (w_rx_dec) begin
            w_rx_par_bit_nxt = w_rx_bit;
            w_rx_any_nxt     = r_rx_any | w_rx_bit;
            w_rx_state_nxt   = RX_STOP;
          end
        end
        RX_STOP: begin
          if (w_rx_dec) begin
            w_rx_state_nxt = RX_IDLE;
            if (!r_rx_any && !w_rx_bit) begin
              w_rx_break_nxt = 1'b1;
              w_rx_state_nxt = RX_BREAK;
            end else if (!r_rx_valid || rx_ready) begin
              // A consumer handshake in this cycle frees the holding register.
              w_rx_data_nxt  = r_rx_shift;
              w_rx_perr_nxt  = r_rx_par_en & (r_rx_acc ^ r_rx_par_odd ^ r_rx_par_bit);
              w_rx_ferr_nxt  = !w_rx_bit;
              w_rx_valid_nxt = 1'b1;
            end else begin
              w_rx_overrun_nxt = 1'b1;
            end
          end
        end
        RX_BREAK: begin
          if (r_rx_filt) begin
            w_rx_state_nxt = RX_IDLE;
          end
        end
        default: begin
          w_rx_state_nxt = RX_IDLE;
        end
      endcase
    end
  end

  // RX state, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_shift   <= '0;
      r_rx_bitcnt  <= '0;
      r_rx_last    <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_acc     <= 1'b0;
      r_rx_par_bit <= 1'b0;
      r_rx_any     <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_break   <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nxt;
      r_rx_cnt     <= w_rx_cnt_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_rx_bitcnt  <= w_rx_bitcnt_nxt;
      r_rx_last    <= w_rx_last_nxt;
      r_rx_par_en  <= w_rx_par_en_nxt;
      r_rx_par_odd <= w_rx_par_odd_nxt;
      r_rx_acc     <= w_rx_acc_nxt;
      r_rx_par_bit <= w_rx_par_bit_nxt;
      r_rx_any     <= w_rx_any_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_rx_perr    <= w_rx_perr_nxt;
      r_rx_ferr    <= w_rx_ferr_nxt;
      r_rx_overrun <= w_rx_overrun_nxt;
      r_rx_break   <= w_rx_break_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_core_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core_cfg
// Purpose  : Directed self-checking bench for uart_core_cfg (OVERSAMPLE=8,
//            FILTER_LEN=3, clk_en every cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core_cfg;

  logic       clk = 1'b0;
  logic       rst_n_sync;
  logic       en;
  logic       clk_en;
  logic [1:0] cfg_nbits;
  logic       cfg_par_en;
  logic       cfg_par_odd;
  logic       cfg_stop2;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_hold;
  logic       tx_busy;
  logic       tx;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_overrun;
  logic       rx_break;

  logic        loop;
  logic        rx_drv;
  int          n_total = 0;
  int          n_bad   = 0;
  int          cnt_break;
  int          cnt_ovr;
  int          seen_valid;
  int          lowcnt;
  logic [15:0] cap;
  logic [9:0]  seq_a5;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_core_cfg #(.OVERSAMPLE(8), .FILTER_LEN(3)) dut (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .en         (en),
    .clk_en     (clk_en),
    .cfg_nbits  (cfg_nbits),
    .cfg_par_en (cfg_par_en),
    .cfg_par_odd(cfg_par_odd),
    .cfg_stop2  (cfg_stop2),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_hold    (tx_hold),
    .tx_busy    (tx_busy),
    .tx         (tx),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_perr    (rx_perr),
    .rx_ferr    (rx_ferr),
    .rx_overrun (rx_overrun),
    .rx_break   (rx_break)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the edge and log RX pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cnt_break += int'(rx_break);
    cnt_ovr   += int'(rx_overrun);
    if (rx_valid) seen_valid++;
  endtask

  task automatic hold_rx(input logic v, input int n);
    rx_drv = v;
    repeat (n) step();
  endtask

  task automatic rx_frame(input logic [7:0] d, input int nb, input logic pe,
                          input logic pb, input logic sb);
    hold_rx(1'b0, 8);
    for (int i = 0; i < nb; i++) hold_rx(d[i], 8);
    if (pe) hold_rx(pb, 8);
    hold_rx(sb, 8);
    hold_rx(1'b1, 24);
  endtask

  task automatic wait_rx(input string tag);
    int got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      if (rx_valid) got = 1;
      else step();
    end
    chk({tag, "_valid"}, got, 1);
  endtask

  task automatic consume(input string tag);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk({tag, "_clr"}, rx_valid, 0);
  endtask

  // Offer a byte and return 1 unit after the handshake edge.
  task automatic send(input logic [7:0] d);
    int ok = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      if (tx_ready) ok = 1;
      else step();
    end
    chk("tx_accept", ok, 1);
    step();
    tx_valid = 1'b0;
  endtask

  // Sample tx at the middle of each bit of the frame just started.
  task automatic grab_tx(input int nbits, output logic [15:0] c);
    c = '0;
    for (int b = 0; b < nbits; b++) begin
      repeat ((b == 0) ? 4 : 8) step();
      c[b] = tx;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n_sync  = 1'b0;
    en          = 1'b0;
    clk_en      = 1'b1;
    cfg_nbits   = 2'd3;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    tx_hold     = 1'b0;
    rx_ready    = 1'b0;
    loop        = 1'b0;
    rx_drv      = 1'b1;
    cnt_break   = 0;
    cnt_ovr     = 0;
    seen_valid  = 0;
    seq_a5      = 10'b1_10100101_0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_perr", rx_perr, 0);
    chk("rst_rx_ferr", rx_ferr, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    chk("rst_rx_break", rx_break, 0);
    rst_n_sync = 1'b1;
    step();
    step();
    chk("idle_tx_ready", tx_ready, 1);

    // 8N1 TX of 0xA5, bit-by-bit every cycle
    send(8'hA5);
    lowcnt = 0;
    for (int k = 0; k < 80; k++) begin
      chk("a5_tx_bit", tx, seq_a5[k / 8]);
      if (!tx_ready) lowcnt++;
      step();
    end
    chk("a5_ready_back", tx_ready, 1);
    chk("a5_ready_low_cycles", lowcnt, 80);

    // 7O2 loopback of 0x55
    cfg_nbits   = 2'd2;
    cfg_par_en  = 1'b1;
    cfg_par_odd = 1'b1;
    cfg_stop2   = 1'b1;
    loop        = 1'b1;
    send(8'h55);
    grab_tx(11, cap);
    chk("7o2_frame", cap[10:0], 11'b111_1010101_0);
    chk("7o2_parity", cap[8], 1);
    wait_rx("7o2");
    chk("7o2_data", rx_data, 8'h55);
    chk("7o2_perr", rx_perr, 0);
    chk("7o2_ferr", rx_ferr, 0);
    consume("7o2");
    repeat (12) step();
    loop = 1'b0;

    // Parity error, then framing error, 8E1 0x3C
    cfg_nbits   = 2'd3;
    cfg_par_en  = 1'b1;
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b0;
    rx_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1);
    wait_rx("perr");
    chk("perr_data", rx_data, 8'h3C);
    chk("perr_perr", rx_perr, 1);
    chk("perr_ferr", rx_ferr, 0);
    consume("perr");
    rx_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0);
    wait_rx("ferr");
    chk("ferr_data", rx_data, 8'h3C);
    chk("ferr_perr", rx_perr, 0);
    chk("ferr_ferr", rx_ferr, 1);
    consume("ferr");

    // Break: 20 bit periods low, then a normal 8N1 frame
    cfg_par_en = 1'b0;
    cnt_break  = 0;
    seen_valid = 0;
    hold_rx(1'b0, 160);
    hold_rx(1'b1, 40);
    chk("brk_pulses", cnt_break, 1);
    chk("brk_no_valid", seen_valid, 0);
    rx_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    wait_rx("brk_next");
    chk("brk_next_data", rx_data, 8'h81);
    chk("brk_next_ferr", rx_ferr, 0);
    consume("brk_next");

    // Overrun: two frames with no consumer
    cnt_ovr = 0;
    rx_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    rx_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    chk("ovr_pulses", cnt_ovr, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    consume("ovr");

    // 2-cycle glitch just ahead of a real frame must not be taken as a start
    cnt_break = 0;
    hold_rx(1'b0, 2);
    hold_rx(1'b1, 3);
    rx_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    wait_rx("glitch");
    chk("glitch_data", rx_data, 8'hA5);
    chk("glitch_ferr", rx_ferr, 0);
    chk("glitch_no_break", cnt_break, 0);
    consume("glitch");

    // Abort mid-frame, then resend 0x0F
    send(8'h0F);
    repeat (30) step();
    en = 1'b0;
    step();
    chk("abort_tx", tx, 1);
    chk("abort_busy", tx_busy, 0);
    en = 1'b1;
    step();
    send(8'h0F);
    grab_tx(10, cap);
    chk("abort_resend", cap[9:0], 10'b1_00001111_0);
    repeat (8) step();
    chk("abort_end_idle", tx_busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_core_cfg.md
Name: uart_core_cfg

Overview:
- Configurable UART transmit/receive engine for RISCBoy-class SoCs. It is the successor to the fixed 8N1 UART datapath, driven by an external oversample tick (clk_en from the shared fractional clock divider).
- Supports 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, break detection and per-frame error flags.
- Exposes valid/ready byte streams so a regblock and FIFOs can sit on top.

Parameters:
- OVERSAMPLE, 8, clk_en ticks per bit period. Power of 2, >= 4.
- FILTER_LEN, 3, consecutive equal synchronised RX samples required before the filtered line changes. Range 1–7.

Ports:
- clk  in  1  clock
- rst_n_sync  in  1  reset, asynchronous, active-low
- en  in  1  core enable; low = synchronous reset of both state machines
- clk_en  in  1  oversample tick, one clk wide
- cfg_nbits  in  2  data bits = 5 + cfg_nbits
- cfg_par_en  in  1  parity bit present
- cfg_par_odd  in  1  1 = odd parity, 0 = even parity
- cfg_stop2  in  1  1 = two stop bits on TX
- tx_data  in  8  TX byte; bits above the configured width are ignored
- tx_valid  in  1  TX byte offered
- tx_ready  out  1  TX byte accepted when tx_valid && tx_ready
- tx_hold  in  1  flow control; inhibits acceptance of a new frame
- tx_busy  out  1  TX state != IDLE
- tx  out  1  serial out
- rx  in  1  serial in (asynchronous)
- rx_data  out  8  received byte, zero-extended above the configured width
- rx_valid  out  1  rx_data/rx_perr/rx_ferr valid, held until rx_ready
- rx_ready  in  1  consumer accept
- rx_perr  out  1  parity error for the held byte
- rx_ferr  out  1  framing error for the held byte
- rx_overrun  out  1  1-cycle pulse: frame completed while rx_valid was high; new frame dropped
- rx_break  out  1  1-cycle pulse: break detected

Behaviour:
- Reset values: tx=1, tx_ready=0, tx_busy=0, rx_data=0, rx_valid=0, rx_perr=0, rx_ferr=0, rx_overrun=0, rx_break=0. Filtered RX line resets to 1.
- en low: same values as reset, applied synchronously. en going low mid-frame aborts the frame immediately; tx returns to 1 on the next clk.
- cfg_* sampled per frame: TX at handshake, RX at start-bit qualification. Changes mid-frame affect the next frame only.
- Bit period = OVERSAMPLE clk_en ticks. Tick counter is W=$clog2(OVERSAMPLE) bits and wraps.
- TX states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - tx_ready = en && state==IDLE && !tx_hold (combinational).
  - On handshake: latch tx_data, zero the tick counter, enter START; tx=0 from the next clk.
  - Each state lasts OVERSAMPLE ticks.
  - DATA shifts LSB first, 5+cfg_nbits bits.
  - PARITY drives XOR(data bits) ^ cfg_par_odd; skipped if !cfg_par_en.
  - STOP1 (then STOP2 if cfg_stop2) drives 1.
  - After the last stop bit: IDLE, tx_ready may assert the same cycle, so back-to-back frames have no idle gap.
  - tx_hold is sampled only in IDLE; an in-flight frame always completes.
- RX front end:
  - 2-flop synchroniser.
  - Filter: the filtered line changes only after FILTER_LEN consecutive equal synchronised samples on clk.
- RX states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on a filtered falling edge, zero the counter and go to START.
  - START: sample at OVERSAMPLE/2 ticks. If the line is high, it is a false start; return to IDLE with no flags. Otherwise re-zero the counter.
  - DATA, PARITY, STOP: each bit is sampled after OVERSAMPLE ticks (mid-bit). Only one stop bit is checked.
  - At STOP sample, completion is classified as follows.
    - Break: all data bits 0, parity sample 0 (if enabled) and stop sample 0. Pulse rx_break, push nothing, go to BREAK. BREAK waits for filtered line = 1, then IDLE.
    - Otherwise, if rx_valid=0: load rx_data, rx_perr (parity mismatch, 0 if parity disabled) and rx_ferr (stop=0), and set rx_valid. Go to IDLE the same cycle, giving a half-bit resync margin.
    - Otherwise (rx_valid=1): pulse rx_overrun, keep the held byte/flags, drop the new frame.
  - Completion in the same cycle as an rx_ready handshake: the handshake wins, and the new frame loads, not an overrun.
  - rx_valid falls on rx_valid && rx_ready unless a frame loads that cycle.
- Parity computed over the configured bits only.

Optional Feature:
- Macro: UART_CORE_CFG_MAJORITY_EN.
- Defined: each RX bit decision (start qualification, data, parity, stop) is the 2-of-3 majority of the filtered line at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, measured from the bit start. The decision takes effect at the third sample.
- Undefined: single sample, as specified in Behaviour.
- Bit-level timing of rx_valid differs by at most one tick between builds.

Test Plan:
- 8N1 TX: OVERSAMPLE=8, clk_en every cycle, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 8 clk; tx_ready low for exactly 80 cycles after the handshake.
- 7O2 TX loopback into RX: send 0x55 (cfg_nbits=2, par_en=1, par_odd=1, stop2=1) -> parity bit 1, two stop bits; RX gives rx_data=0x55, rx_perr=0, rx_ferr=0.
- Errors: RX frame 0x3C 8E1 with parity bit inverted -> rx_perr=1; repeat with stop=0 -> rx_ferr=1, rx_data=0x3C.
- Break: hold rx low for 20 bit periods -> one rx_break pulse, rx_valid stays 0; after rx returns high, the next frame 0x81 is received correctly.
- Overrun and glitch: two frames (0x11, 0x22) with rx_ready=0 -> rx_data=0x11, one rx_overrun pulse; a 2-cycle low glitch with FILTER_LEN=3 -> no start detected.
- Abort: drop en mid-TX-frame -> tx=1 next cycle, tx_busy=0; re-enable and send 0x0F -> correct frame.
